// File: rtl/cpci_dma_sched_pkg.sv
// Shared encodings for the CPCI DMA scheduler: FSM states, transfer direction
// and interrupt status bit positions (match CPCI_INTERRUPT_STATUS).
package cpci_dma_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArb,
      StStart,
      StXfer,
      StFault
   } state_e;

   localparam logic DIR_INGR = 1'b0;
   localparam logic DIR_EGR  = 1'b1;

   localparam int unsigned INT_INGR_DONE = 0;
   localparam int unsigned INT_EGR_DONE  = 1;
   localparam int unsigned INT_PKT_AVAIL = 2;
   localparam int unsigned INT_ERR       = 3;
   localparam int unsigned INT_TMO       = 4;
   localparam int unsigned INT_OVF       = 5;
   localparam int unsigned INT_W         = 6;

endpackage

// File: rtl/cpci_rr_arb.sv
// Round-robin queue picker: searches from ptr+1 upward (wrapping) and moves
// the pointer to the granted queue only when the caller accepts the grant.
module cpci_rr_arb #(
   parameter int unsigned NUM_QUEUES = 4,
   parameter int unsigned QW         = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [NUM_QUEUES-1:0] req,
   input  logic                  advance,
   output logic [QW-1:0]         grant,
   output logic                  valid
);

   logic [QW-1:0] ptr_q;
   logic [QW-1:0] idx;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ptr_q <= '0;
      end else if (advance && valid) begin
         ptr_q <= grant;
      end
   end

   // Last match of i=1..N is ptr itself, so the current holder has lowest priority.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
         idx = QW'((32'(ptr_q) + i) % NUM_QUEUES);
         if (!valid && req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpci_dma_sched.sv
// Sequences the single CPCI DMA engine between host egress requests and
// per-queue ingress packets, and raises the DMA/pkt-avail interrupt status.
module cpci_dma_sched
   import cpci_dma_sched_pkg::*;
#(
   parameter int unsigned NUM_QUEUES  = 4,
   parameter int unsigned QW          = 2,
   parameter int unsigned SIZE_W      = 11,
   parameter int unsigned TIMEOUT_W   = 16,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [NUM_QUEUES-1:0] ingr_avail,
   input  logic                  ingr_arm,
   input  logic                  egr_req,
   input  logic [QW-1:0]         egr_queue,
   input  logic [SIZE_W-1:0]     egr_size,
   output logic                  dma_start,
   output logic                  dma_dir,
   output logic [QW-1:0]         dma_queue,
   output logic [SIZE_W-1:0]     dma_size,
   input  logic                  dma_done,
   input  logic                  dma_err,
   output logic [INT_W-1:0]      int_status,
   input  logic [INT_W-1:0]      int_clr,
   output logic                  busy
);

   state_e              state_q, state_d;
   logic                pend_q;
   logic [QW-1:0]       pend_queue_q;
   logic [SIZE_W-1:0]   pend_size_q;
   logic                armed_q;
   logic                last_dir_q;
   logic [TIMEOUT_W-1:0] cnt_q;
   logic                dir_q;
   logic [QW-1:0]       queue_q;
   logic [SIZE_W-1:0]   size_q;
   logic [INT_W-1:0]    status_q, status_d, status_set;

   logic          arb_valid;
   logic [QW-1:0] arb_grant;
   logic          ingr_elig, pick_egr, pick_ingr;
   logic          xfer_done, xfer_err, xfer_tmo;

   cpci_rr_arb #(
      .NUM_QUEUES (NUM_QUEUES),
      .QW         (QW)
   ) u_rr_arb (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .req     (ingr_avail),
      .advance (pick_ingr && (state_q == StArb)),
      .grant   (arb_grant),
      .valid   (arb_valid)
   );

   // Tie between directions alternates; last_dir resets to ingress so egress wins first.
   assign ingr_elig = armed_q && arb_valid;
   assign pick_egr  = pend_q && (!ingr_elig || (last_dir_q == DIR_INGR));
   assign pick_ingr = ingr_elig && !pick_egr;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (pend_q || (armed_q && |ingr_avail)) state_d = StArb;
         StArb:   state_d = (pick_egr || pick_ingr) ? StStart : StIdle;
         StStart: state_d = StXfer;
         StXfer: begin
            if (xfer_err || xfer_tmo) begin
               state_d = StFault;
            end else if (xfer_done) begin
               state_d = StIdle;
            end
         end
         StFault: if (!status_d[INT_ERR] && !status_d[INT_TMO]) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dma_start  = (state_q == StStart);
      busy       = (state_q != StIdle);
      dma_dir    = dir_q;
      dma_queue  = queue_q;
      dma_size   = size_q;
      int_status = status_q;
   end

   // Error beats done; done beats a coincident timeout.
   always_comb begin
      xfer_err  = (state_q == StXfer) && dma_err;
      xfer_done = (state_q == StXfer) && dma_done && !dma_err;
      xfer_tmo  = (state_q == StXfer) && !dma_err && !dma_done &&
                  (cnt_q == TIMEOUT_W'(TIMEOUT_CYC - 1));
   end

   always_comb begin
      status_set                = '0;
      status_set[INT_INGR_DONE] = xfer_done && (dir_q == DIR_INGR);
      status_set[INT_EGR_DONE]  = xfer_done && (dir_q == DIR_EGR);
      status_set[INT_PKT_AVAIL] = (|ingr_avail) && !armed_q && !busy;
      status_set[INT_ERR]       = xfer_err;
      status_set[INT_TMO]       = xfer_tmo;
      status_set[INT_OVF]       = egr_req && pend_q;
      status_d                  = (status_q & ~int_clr) | status_set;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pend_q       <= 1'b0;
         pend_queue_q <= '0;
         pend_size_q  <= '0;
         armed_q      <= 1'b0;
         last_dir_q   <= DIR_INGR;
         cnt_q        <= '0;
         dir_q        <= DIR_INGR;
         queue_q      <= '0;
         size_q       <= '0;
         status_q     <= '0;
      end else begin
         status_q <= status_d;

         if (egr_req && !pend_q) begin
            pend_q       <= 1'b1;
            pend_queue_q <= egr_queue;
            pend_size_q  <= egr_size;
         end else if (xfer_done && (dir_q == DIR_EGR)) begin
            pend_q <= 1'b0;
         end

         if (ingr_arm) begin
            armed_q <= 1'b1;
         end else if ((state_q == StStart) && (dir_q == DIR_INGR)) begin
            armed_q <= 1'b0;
         end

         if (state_q == StArb) begin
            if (pick_egr) begin
               dir_q      <= DIR_EGR;
               queue_q    <= pend_queue_q;
               size_q     <= pend_size_q;
               last_dir_q <= DIR_EGR;
            end else if (pick_ingr) begin
               dir_q      <= DIR_INGR;
               queue_q    <= arb_grant;
               size_q     <= '0;
               last_dir_q <= DIR_INGR;
            end
         end

         if (state_q == StStart) begin
            cnt_q <= '0;
         end else if (state_q == StXfer) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cpci_dma_sched.sv
// Directed bench for cpci_dma_sched: latency, round-robin, direction tie,
// timeout, err/done collision, overflow and mid-transfer reset.
module tb_cpci_dma_sched;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [3:0]  ingr_avail;
   logic        ingr_arm;
   logic        egr_req;
   logic [1:0]  egr_queue;
   logic [10:0] egr_size;
   logic        dma_start;
   logic        dma_dir;
   logic [1:0]  dma_queue;
   logic [10:0] dma_size;
   logic        dma_done;
   logic        dma_err;
   logic [5:0]  int_status;
   logic [5:0]  int_clr;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   cpci_dma_sched dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .ingr_avail (ingr_avail),
      .ingr_arm   (ingr_arm),
      .egr_req    (egr_req),
      .egr_queue  (egr_queue),
      .egr_size   (egr_size),
      .dma_start  (dma_start),
      .dma_dir    (dma_dir),
      .dma_queue  (dma_queue),
      .dma_size   (dma_size),
      .dma_done   (dma_done),
      .dma_err    (dma_err),
      .int_status (int_status),
      .int_clr    (int_clr),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_start(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (dma_start) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic pulse_done();
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
   endtask

   task automatic clear_all();
      int_clr = 6'h3f;
      step();
      int_clr = 6'h00;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      step();
      step();
      RST_N = 1'b1;
   endtask

   initial begin
      ingr_avail = '0; ingr_arm = 0; egr_req = 0; egr_queue = '0; egr_size = '0;
      dma_done = 0; dma_err = 0; int_clr = '0;
      do_reset();

      check("rst_status", 32'(int_status), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(dma_start), 32'd0);
      check("rst_outs", {20'd0, dma_dir, dma_queue, dma_size}, 32'd0);

      // 1: egress latency and completion
      egr_req = 1; egr_queue = 2'd2; egr_size = 11'd64;
      step();
      egr_req = 0;
      check("t1_lat1", 32'(dma_start), 32'd0);
      step();
      check("t1_lat2", 32'(dma_start), 32'd0);
      step();
      check("t1_start", 32'(dma_start), 32'd1);
      check("t1_dir", 32'(dma_dir), 32'd1);
      check("t1_queue", 32'(dma_queue), 32'd2);
      check("t1_size", 32'(dma_size), 32'd64);
      check("t1_busy", 32'(busy), 32'd1);
      step();
      check("t1_pulse", 32'(dma_start), 32'd0);
      pulse_done();
      check("t1_status", 32'(int_status), 32'h02);
      check("t1_idle", 32'(busy), 32'd0);
      clear_all();

      // 2: round-robin over 4'b1010 from rr_ptr=0
      ingr_avail = 4'b1010;
      ingr_arm = 1;
      step();
      ingr_arm = 0;
      wait_start("t2_start_a");
      check("t2_dir", 32'(dma_dir), 32'd0);
      check("t2_q_a", 32'(dma_queue), 32'd1);
      check("t2_size", 32'(dma_size), 32'd0);
      step();
      pulse_done();
      ingr_arm = 1;
      step();
      ingr_arm = 0;
      wait_start("t2_start_b");
      check("t2_q_b", 32'(dma_queue), 32'd3);
      step();
      pulse_done();
      ingr_arm = 1;
      step();
      ingr_arm = 0;
      wait_start("t2_start_c");
      check("t2_q_c", 32'(dma_queue), 32'd1);
      step();
      pulse_done();
      check("t2_status", 32'(int_status), 32'h05);
      ingr_avail = '0;
      clear_all();

      // 3: egress and ingress both eligible after reset -> egress first
      do_reset();
      egr_req = 1; egr_queue = 2'd0; egr_size = 11'd100;
      ingr_arm = 1; ingr_avail = 4'b0001;
      step();
      egr_req = 0; ingr_arm = 0;
      wait_start("t3_start_e");
      check("t3_dir_e", 32'(dma_dir), 32'd1);
      check("t3_size_e", 32'(dma_size), 32'd100);
      step();
      pulse_done();
      wait_start("t3_start_i");
      check("t3_dir_i", 32'(dma_dir), 32'd0);
      check("t3_q_i", 32'(dma_queue), 32'd0);
      step();
      pulse_done();
      check("t3_status", 32'(int_status), 32'h07);
      ingr_avail = '0;
      clear_all();

      // 4: timeout after 50000 XFER cycles, then clear tmo
      ingr_avail = 4'b0001;
      ingr_arm = 1;
      step();
      ingr_arm = 0;
      wait_start("t4_start");
      begin
         int  cyc = 0;
         bit  hit = 0;
         for (int i = 0; i < 50100; i++) begin
            step();
            cyc++;
            if (int_status[4]) begin
               hit = 1;
               break;
            end
         end
         check("t4_tmo_seen", 32'(hit), 32'd1);
         check("t4_tmo_cycles", 32'(cyc), 32'd50001);
      end
      check("t4_status", 32'(int_status), 32'h14);
      step();
      step();
      check("t4_hold", 32'(busy), 32'd1);
      int_clr = 6'b010000;
      step();
      int_clr = '0;
      check("t4_idle", 32'(busy), 32'd0);
      check("t4_status_clr", 32'(int_status), 32'h04);
      ingr_avail = '0;
      clear_all();

      // 5: overflow, then err and done together
      egr_req = 1; egr_queue = 2'd3; egr_size = 11'd200;
      step();
      egr_queue = 2'd1; egr_size = 11'd5;
      step();
      egr_req = 0;
      wait_start("t5_start_a");
      check("t5_q_a", 32'(dma_queue), 32'd3);
      check("t5_size_a", 32'(dma_size), 32'd200);
      step();
      dma_done = 1; dma_err = 1;
      step();
      dma_done = 0; dma_err = 0;
      check("t5_status_err", 32'(int_status), 32'h28);
      step();
      check("t5_fault_hold", 32'(busy), 32'd1);
      int_clr = 6'b001000;
      step();
      int_clr = '0;
      wait_start("t5_start_b");
      check("t5_q_b", 32'(dma_queue), 32'd3);
      check("t5_size_b", 32'(dma_size), 32'd200);
      step();
      pulse_done();
      check("t5_status_done", 32'(int_status), 32'h22);
      repeat (5) step();
      check("t5_dropped", 32'(busy), 32'd0);
      clear_all();

      // 6: reset mid-transfer, late done ignored
      egr_req = 1; egr_queue = 2'd1; egr_size = 11'd8;
      step();
      egr_req = 0;
      wait_start("t6_start");
      step();
      RST_N = 0;
      step();
      RST_N = 1;
      pulse_done();
      check("t6_status", 32'(int_status), 32'h00);
      check("t6_outs", {19'd0, busy, dma_start, dma_dir, dma_queue, dma_size}, 32'd0);
      repeat (5) step();
      check("t6_no_restart", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
